// File: rtl/cla_result_fifo.sv
// Result FIFO behind the 64-bit CLA: buffers {carry, sum} words and hands them out over valid/ready.
// Also tracks a sticky overflow flag and a saturating count of accepted carry-out results.
module cla_result_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_sum,
    input  logic              in_carry,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_carry,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [CCNT_W-1:0] carry_cnt
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
    localparam logic [CCNT_W-1:0] CarryOne  = CCNT_W'(1);
    localparam logic [CCNT_W-1:0] CarryMax  = '1;

    logic [WIDTH:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [CCNT_W-1:0]   carry_cnt_q, carry_cnt_d;
    logic                push, pop;
    logic [WIDTH:0]      head;

    // Full blocks the push even when a pop happens in the same cycle.
    assign in_ready  = (count_q != FullCount);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_sum   = out_valid ? head[WIDTH-1:0] : '0;
    assign out_carry = out_valid ? head[WIDTH]     : 1'b0;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign carry_cnt = carry_cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        carry_cnt_d = carry_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (pop && !push) begin
            count_d = count_q - CountOne;
        end

        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end

        if (push && in_carry && (carry_cnt_q != CarryMax)) begin
            carry_cnt_d = carry_cnt_q + CarryOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    // Storage is never cleared; stale words are masked by the occupancy count.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {in_carry, in_sum};
        end
    end

endmodule

// File: tb/tb_cla_result_fifo.sv
// Randomized and directed bench for cla_result_fifo against a queue-based reference model.
// A second instance with a 2-bit carry counter covers counter saturation.
module tb_cla_result_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             inValid, inCarry, outReady;
    logic [WIDTH-1:0] inSum;
    logic             inReady, outValid, outCarry, overflow;
    logic [WIDTH-1:0] outSum;
    logic [2:0]       count;
    logic [7:0]       carryCnt;

    logic             sInValid, sInCarry, sOutReady;
    logic [WIDTH-1:0] sInSum;
    logic             sInReady, sOutValid, sOutCarry, sOverflow;
    logic [WIDTH-1:0] sOutSum;
    logic [2:0]       sCount;
    logic [1:0]       sCarryCnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] modelQ[$];
    bit             modelOvf;
    int             modelCarry;

    cla_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(2), .CCNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(inValid), .in_sum(inSum), .in_carry(inCarry), .in_ready(inReady),
        .out_valid(outValid), .out_sum(outSum), .out_carry(outCarry), .out_ready(outReady),
        .count(count), .overflow(overflow), .carry_cnt(carryCnt)
    );

    cla_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(2), .CCNT_W(2)) dutSat (
        .clock(clock), .reset(reset),
        .in_valid(sInValid), .in_sum(sInSum), .in_carry(sInCarry), .in_ready(sInReady),
        .out_valid(sOutValid), .out_sum(sOutSum), .out_carry(sOutCarry), .out_ready(sOutReady),
        .count(sCount), .overflow(sOverflow), .carry_cnt(sCarryCnt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [WIDTH:0] observed, input logic [WIDTH:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [WIDTH:0] head;
        head = (modelQ.size() != 0) ? modelQ[0] : '0;
        checkOutput({tag, ".count"},    65'(count),    65'(modelQ.size()));
        checkOutput({tag, ".outValid"}, 65'(outValid), 65'(modelQ.size() != 0));
        checkOutput({tag, ".outSum"},   65'(outSum),   65'(head[WIDTH-1:0]));
        checkOutput({tag, ".outCarry"}, 65'(outCarry), 65'(head[WIDTH]));
        checkOutput({tag, ".inReady"},  65'(inReady),  65'(modelQ.size() != DEPTH));
        checkOutput({tag, ".overflow"}, 65'(overflow), 65'(modelOvf));
        checkOutput({tag, ".carryCnt"}, 65'(carryCnt), 65'(modelCarry));
    endtask

    // One clock of the main instance: drive, advance the model by its rules, then compare after the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [WIDTH-1:0] s,
                                 input logic c, input logic rdy);
        bit doPush, doPop;
        inValid  = v;
        inSum    = s;
        inCarry  = c;
        outReady = rdy;
        doPush = v && (modelQ.size() != DEPTH);
        doPop  = rdy && (modelQ.size() != 0);
        if (v && !doPush) modelOvf = 1'b1;
        @(posedge clock);
        #1;
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
            modelQ.push_back({c, s});
            if (c && modelCarry < 255) modelCarry++;
        end
        checkAll(tag);
    endtask

    task automatic doReset(input int cycles);
        reset    = 1'b1;
        inValid  = 1'b0;
        inSum    = '0;
        inCarry  = 1'b0;
        outReady = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
        modelQ.delete();
        modelOvf   = 1'b0;
        modelCarry = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] data;
        int expSat;
        sInValid = 1'b0; sInSum = '0; sInCarry = 1'b0; sOutReady = 1'b0;

        $display("[TB] reset release");
        doReset(2);
        checkAll("reset");
        checkOutput("reset.sat.carryCnt", 65'(sCarryCnt), 65'd0);

        $display("[TB] single pass-through");
        applyStimulus("single.push", 1'b1, 64'h6789_ABCD_E601_ABCC, 1'b0, 1'b0);
        checkOutput("single.literalSum", 65'(outSum), 65'(64'h6789_ABCD_E601_ABCC));
        applyStimulus("single.pop", 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 5; i++) applyStimulus("fill", 1'b1, 64'(i), 1'b1, 1'b0);
        checkOutput("fill.overflowSet", 65'(overflow), 65'd1);
        checkOutput("fill.carryCnt4", 65'(carryCnt), 65'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain.order", 65'(outSum), 65'(i));
            applyStimulus("drain", 1'b0, '0, 1'b0, 1'b1);
        end

        $display("[TB] simultaneous push and pop");
        applyStimulus("pp.pre", 1'b1, 64'd100, 1'b0, 1'b0);
        applyStimulus("pp.pre", 1'b1, 64'd101, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("pp.head", 65'(outSum), 65'(100 + i));
            applyStimulus("pp", 1'b1, 64'(102 + i), 1'b0, 1'b1);
            checkOutput("pp.count2", 65'(count), 65'd2);
        end

        $display("[TB] mid-operation reset");
        applyStimulus("mid.pre", 1'b1, 64'hDEAD, 1'b1, 1'b0);
        checkOutput("mid.count3", 65'(count), 65'd3);
        doReset(1);
        checkAll("mid.reset");
        applyStimulus("mid.push", 1'b1, 64'hBEEF_0001, 1'b1, 1'b0);

        $display("[TB] carry counter saturation");
        expSat = 0;
        for (int i = 0; i < 5; i++) begin
            sInValid = 1'b1; sInSum = 64'(i + 7); sInCarry = 1'b1; sOutReady = 1'b0;
            @(posedge clock);
            #1;
            sInValid = 1'b0;
            if (expSat < 3) expSat++;
            checkOutput("sat.carryCnt", 65'(sCarryCnt), 65'(expSat));
            checkOutput("sat.head", 65'(sOutSum), 65'(i + 7));
            sOutReady = 1'b1;
            @(posedge clock);
            #1;
            sOutReady = 1'b0;
            checkOutput("sat.empty", 65'(sOutValid), 65'd0);
        end

        $display("[TB] random traffic");
        doReset(1);
        checkAll("rand.reset");
        for (int i = 0; i < 400; i++) begin
            data = {$urandom, $urandom};
            applyStimulus("rand", 1'($urandom_range(0, 99) < 60), data,
                          1'($urandom), 1'($urandom_range(0, 99) < 45));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_result_fifo.md
Name: cla_result_fifo

Overview:
- Downstream stage of the 64-bit carry-lookahead adder (CLA_64).
- Captures each adder result ({crout, sum}) into a small synchronous FIFO.
- Presents results to the consumer over a valid/ready handshake, decoupling adder issue rate from consumer back-pressure.
- Keeps a sticky overflow flag and a saturating count of results that produced a carry-out.

Parameters:
WIDTH, 64, data width of the sum word
DEPTH, 4, number of entries (power of two, >= 2)
ADDR_W, 2, log2(DEPTH); pointer width
CCNT_W, 8, width of carry-out event counter

Ports:
clock  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
in_valid  input  1  adder result present this cycle
in_sum  input  WIDTH  adder sum
in_carry  input  1  adder carry-out (crout)
in_ready  output  1  FIFO can accept an entry this cycle
out_valid  output  1  head entry available
out_sum  output  WIDTH  head entry sum
out_carry  output  1  head entry carry
out_ready  input  1  consumer takes head entry this cycle
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: in_valid asserted while full
carry_cnt  output  CCNT_W  saturating count of accepted entries with in_carry=1

Behaviour:
- Reset is synchronous and active-high, sampled on the rising clock edge.
  - On reset: wr_ptr=0, rd_ptr=0, count=0, overflow=0, carry_cnt=0.
  - All FIFO contents are discarded, including a reset asserted mid-stream.
  - Memory contents are not cleared.
- in_ready = (count != DEPTH); combinational from registered count. No pass-through when full: a pop in the same cycle does not make room for that cycle's push.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- On push: mem[wr_ptr] <= {in_carry, in_sum}; wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push & pop together, or on neither
- out_valid = (count != 0).
- out_sum/out_carry = mem[rd_ptr] when out_valid, forced to 0 when empty (show-ahead head, no read latency).
- Latency: an entry pushed at edge N is visible at outputs after edge N; an empty-FIFO push/pop bypass does not exist.
- Empty case: out_ready while empty has no effect; pointers and count are unchanged.
- Full case: in_valid while full sets overflow=1 at that edge. The data is dropped and the pointers are unchanged. overflow stays set until reset.
- carry_cnt increments on each push with in_carry=1 and saturates at 2^CCNT_W-1. It is unaffected by overflow-dropped inputs.
- Ordering: strict FIFO, no reordering. The head stays stable while out_valid=1 and out_ready=0.
- All outputs are derived from registers or from memory indexed by registers; there is no combinational path from in_* to out_*.

Test Plan:
- Reset release:
  - Stimulus: hold reset 1 for 2 cycles, then release.
  - Required: count=0, out_valid=0, out_sum=0, in_ready=1, overflow=0, carry_cnt=0.
- Single pass-through:
  - Stimulus: push in_sum=64'h6789_ABCD_E601_ABCC, in_carry=0 (CLA_64 result of 64'h1234_5678_90ab_cdef + 64'h5555_5555_5555_dddd), with out_ready=0.
  - Required: after the edge, out_valid=1, out_sum=64'h6789_ABCD_E601_ABCC, out_carry=0, count=1.
  - Then assert out_ready=1 for one cycle. Required: count=0, out_valid=0.
- Fill and overflow:
  - Stimulus: push 5 entries, values 1..5 with in_carry=1, out_ready=0.
  - Required: in_ready=0 after the 4th push; the 5th is dropped and overflow=1; count=4; carry_cnt=4.
  - Then drain. Required: out_sum sequence 1,2,3,4; overflow remains 1.
- Simultaneous push and pop:
  - Stimulus: with count=2, hold in_valid=1 and out_ready=1 for 6 cycles with incrementing data.
  - Required: count stays 2, pointers wrap past DEPTH, outputs appear in order with no loss.
- Mid-operation reset:
  - Stimulus: with count=3 and overflow=1, assert reset for 1 cycle.
  - Required: count=0, out_valid=0, overflow=0, carry_cnt=0; a new push afterwards appears at the head.
- carry_cnt saturation:
  - Stimulus: set CCNT_W=2 and push/pop 5 entries with in_carry=1.
  - Required: carry_cnt reads 1,2,3,3,3.
